ifmap_bank_loader: RTL and testbench

IFMAP_BANK_LOADER -- requirements
Module: ifmap_bank_loader

---
 rtl/conv_pkg.sv | 22 ++
 rtl/ifmap_lane_packer.sv | 64 ++++++
 rtl/ifmap_bank_loader.sv | 196 +++++++++++++++++++
 tb/tb_ifmap_bank_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the ifmap bank loader: FSM state encoding and latched job configuration.
package conv_pkg;

    typedef enum logic [1:0] {
        LS_IDLE      = 2'd0,
        LS_FILL      = 2'd1,
        LS_WAIT_FREE = 2'd2
    } loader_state_e;

    // Fields are held at a fixed width so the struct is independent of the loader's parameters.
    localparam int CFG_FIELD_W = 32;

    typedef struct packed {
        logic [CFG_FIELD_W-1:0] bank_words;
        logic [CFG_FIELD_W-1:0] num_banks;
    } loader_cfg_t;

    function automatic logic [CFG_FIELD_W-1:0] cfg_last(input logic [CFG_FIELD_W-1:0] n);
        return n - CFG_FIELD_W'(1);
    endfunction

endpackage

// File: rtl/ifmap_lane_packer.sv
// Packs consecutive ifmap words into a LANES-wide vector (lane 0 in LSBs) and emits it one
// cycle after the last lane arrives; a flush emits a partial vector with unfilled lanes zero.
module ifmap_lane_packer #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_dat,
    input  logic                     flush,
    output logic                     partial,
    output logic                     launch,
    output logic                     vec_vld,
    output logic [DATA_W*LANES-1:0]  vec_dat
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0]              lane_cnt;
    logic [DATA_W*LANES-1:0]    acc;
    logic [DATA_W*LANES-1:0]    acc_nxt;
    logic                       last_lane;

    assign last_lane = (lane_cnt == LW'(LANES - 1));
    assign partial   = (lane_cnt != '0);
    assign launch    = (push && last_lane) || (flush && partial);

    always_comb begin
        acc_nxt = acc;
        acc_nxt[int'(lane_cnt)*DATA_W +: DATA_W] = push_dat;
    end

    // The accumulator is zeroed after every emit, which is what provides the zero fill on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            acc      <= '0;
            vec_vld  <= 1'b0;
            vec_dat  <= '0;
        end else begin
            vec_vld <= launch && !clear;
            if (clear) begin
                lane_cnt <= '0;
                acc      <= '0;
            end else if (push) begin
                if (last_lane) begin
                    vec_dat  <= acc_nxt;
                    acc      <= '0;
                    lane_cnt <= '0;
                end else begin
                    acc      <= acc_nxt;
                    lane_cnt <= lane_cnt + LW'(1);
                end
            end else if (flush && partial) begin
                vec_dat  <= acc;
                acc      <= '0;
                lane_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ifmap_bank_loader.sv
// Streams ifmap words into a double-buffered bank, handing banks to the reader under a credit
// scheme. Optional early job termination via the flush port when LOADER_FLUSH_EN is defined.
module ifmap_bank_loader
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        ifmap_dat,
    input  logic                     ifmap_vld,
    output logic                     ifmap_rdy,
    input  logic [ADDR_W:0]          cfg_bank_words,
    input  logic [CNT_W-1:0]         cfg_num_banks,
    input  logic                     cfg_vld,
    output logic                     cfg_rdy,
    output logic                     wen,
    output logic [ADDR_W-1:0]        wadr,
    output logic [DATA_W*LANES-1:0]  wdata,
    output logic                     switch_banks,
    input  logic                     bank_free,
    output logic                     job_done,
`ifdef LOADER_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     busy
);

    loader_state_e      state;
    loader_state_e      state_nxt;
    loader_cfg_t        cfg;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   sw_cnt;
    logic               credit;
    logic               bank_end_q;
    logic               flush_end_q;
    logic               flush_hold;
    logic               init_done;

    logic               cfg_acc;
    logic               cfg_noop;
    logic               push;
    logic               launch;
    logic               partial;
    logic               flush_req;
    logic               flush_act;
    logic               free_ok;
    logic               last_sw;
    logic               at_last_addr;

`ifdef LOADER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign cfg_rdy      = (state == LS_IDLE) && init_done;
    assign cfg_acc      = cfg_vld && cfg_rdy;
    assign cfg_noop     = (cfg_bank_words == '0) || (cfg_num_banks == '0);
    assign free_ok      = credit || bank_free;
    assign last_sw      = flush_end_q ||
                          ((CFG_FIELD_W'(sw_cnt) + CFG_FIELD_W'(1)) == cfg.num_banks);
    assign at_last_addr = (CFG_FIELD_W'(addr) == cfg_last(cfg.bank_words));
    assign busy         = (state != LS_IDLE);

    // Input is held off while a flush is pending, and during a bank-closing write that will
    // either stall for a free bank or end the job, so no word spills past the bank boundary.
    assign ifmap_rdy = (state == LS_FILL) && !flush_req && !flush_hold &&
                       !(wen && bank_end_q && (!free_ok || last_sw));
    assign push      = ifmap_vld && ifmap_rdy;

    ifmap_lane_packer #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cfg_acc),
        .push     (push),
        .push_dat (ifmap_dat),
        .flush    (flush_act),
        .partial  (partial),
        .launch   (launch),
        .vec_vld  (wen),
        .vec_dat  (wdata)
    );

    always_comb begin
        state_nxt    = state;
        switch_banks = 1'b0;
        job_done     = 1'b0;
        flush_act    = 1'b0;
        case (state)
            LS_IDLE: begin
                if (cfg_acc && !cfg_noop) begin
                    state_nxt = LS_FILL;
                end
            end
            LS_FILL: begin
                if (wen && bank_end_q) begin
                    if (free_ok) begin
                        switch_banks = 1'b1;
                        if (last_sw) begin
                            job_done  = 1'b1;
                            state_nxt = LS_IDLE;
                        end
                    end else begin
                        state_nxt = LS_WAIT_FREE;
                    end
                end else if (!wen && (flush_req || flush_hold)) begin
                    flush_act = 1'b1;
                    // With a partial vector the bank closes on the resulting write instead.
                    if (!partial) begin
                        if (addr == '0) begin
                            job_done  = 1'b1;
                            state_nxt = LS_IDLE;
                        end else if (free_ok) begin
                            switch_banks = 1'b1;
                            job_done     = 1'b1;
                            state_nxt    = LS_IDLE;
                        end else begin
                            state_nxt = LS_WAIT_FREE;
                        end
                    end
                end
            end
            LS_WAIT_FREE: begin
                if (bank_free) begin
                    switch_banks = 1'b1;
                    if (last_sw) begin
                        job_done  = 1'b1;
                        state_nxt = LS_IDLE;
                    end else begin
                        state_nxt = LS_FILL;
                    end
                end
            end
            default: state_nxt = LS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LS_IDLE;
            init_done   <= 1'b0;
            cfg         <= '0;
            addr        <= '0;
            sw_cnt      <= '0;
            credit      <= 1'b1;
            bank_end_q  <= 1'b0;
            flush_end_q <= 1'b0;
            flush_hold  <= 1'b0;
            wadr        <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= 1'b1;
            credit    <= cfg_acc ? 1'b1 : ((credit && !switch_banks) || bank_free);

            if (cfg_acc) begin
                cfg.bank_words <= CFG_FIELD_W'(cfg_bank_words);
                cfg.num_banks  <= CFG_FIELD_W'(cfg_num_banks);
                addr           <= '0;
                sw_cnt         <= '0;
                bank_end_q     <= 1'b0;
                flush_end_q    <= 1'b0;
            end else begin
                if (switch_banks) begin
                    sw_cnt <= sw_cnt + CNT_W'(1);
                end
                if (launch) begin
                    wadr       <= addr;
                    bank_end_q <= flush_act || at_last_addr;
                    if (!flush_act) begin
                        addr <= at_last_addr ? '0 : addr + ADDR_W'(1);
                    end
                end
                if (flush_act) begin
                    flush_end_q <= 1'b1;
                end
            end

            // A flush that lands on a write cycle is remembered and acted on once the write retires.
            if (state_nxt == LS_IDLE) begin
                flush_hold <= 1'b0;
            end else if ((state == LS_FILL) && wen && (flush_req || flush_hold) && !flush_end_q) begin
                flush_hold <= 1'b1;
            end else if (flush_act) begin
                flush_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_bank_loader.sv
// Scoreboard bench for ifmap_bank_loader: expected writes/switches are queued as stimulus is
// driven and matched against DUT output events. Flush scenario runs when LOADER_FLUSH_EN is defined.
module tb_ifmap_bank_loader;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam int VEC_W  = DATA_W * LANES;
    localparam int BW_W   = ADDR_W + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DATA_W-1:0]  ifmap_dat = '0;
    logic               ifmap_vld = 1'b0;
    logic               ifmap_rdy;
    logic [ADDR_W:0]    cfg_bank_words = '0;
    logic [CNT_W-1:0]   cfg_num_banks = '0;
    logic               cfg_vld = 1'b0;
    logic               cfg_rdy;
    logic               wen;
    logic [ADDR_W-1:0]  wadr;
    logic [VEC_W-1:0]   wdata;
    logic               switch_banks;
    logic               bank_free = 1'b0;
    logic               job_done;
    logic               busy;
    logic               flush = 1'b0;

    ifmap_bank_loader #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifmap_dat      (ifmap_dat),
        .ifmap_vld      (ifmap_vld),
        .ifmap_rdy      (ifmap_rdy),
        .cfg_bank_words (cfg_bank_words),
        .cfg_num_banks  (cfg_num_banks),
        .cfg_vld        (cfg_vld),
        .cfg_rdy        (cfg_rdy),
        .wen            (wen),
        .wadr           (wadr),
        .wdata          (wdata),
        .switch_banks   (switch_banks),
        .bank_free      (bank_free),
        .job_done       (job_done),
`ifdef LOADER_FLUSH_EN
        .flush          (flush),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               wen;
        logic [ADDR_W-1:0]  adr;
        logic [VEC_W-1:0]   data;
        logic               sw;
        logic               done;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;

    // Output-event scoreboard: every wen / switch_banks / job_done cycle must match the queue head.
    always @(negedge clk) begin
        if (rst_n && (wen || switch_banks || job_done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got wen=%b adr=%0d data=%h sw=%b done=%b (none expected)",
                         wen, wadr, wdata, switch_banks, job_done);
            end else begin
                mon_e = exp_q.pop_front();
                if (wen !== mon_e.wen || (mon_e.wen && (wadr !== mon_e.adr || wdata !== mon_e.data)) ||
                    switch_banks !== mon_e.sw || job_done !== mon_e.done) begin
                    errors++;
                    $display("FAIL event got wen=%b adr=%0d data=%h sw=%b done=%b want wen=%b adr=%0d data=%h sw=%b done=%b",
                             wen, wadr, wdata, switch_banks, job_done,
                             mon_e.wen, mon_e.adr, mon_e.data, mon_e.sw, mon_e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_write(input int adr, input logic [VEC_W-1:0] data, input logic sw, input logic done);
        ev_t e;
        e.wen = 1'b1; e.adr = ADDR_W'(adr); e.data = data; e.sw = sw; e.done = done;
        exp_q.push_back(e);
    endtask

    task automatic exp_switch(input logic done);
        ev_t e;
        e.wen = 1'b0; e.adr = '0; e.data = '0; e.sw = 1'b1; e.done = done;
        exp_q.push_back(e);
    endtask

    task automatic configure(input int bw, input int nb);
        int n;
        n = 0;
        while (!cfg_rdy && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_rdy !== 1'b1) begin
            errors++;
            $display("FAIL cfg_rdy_wait got=%b want=1", cfg_rdy);
        end
        cfg_bank_words = BW_W'(bw);
        cfg_num_banks  = CNT_W'(nb);
        cfg_vld        = 1'b1;
        tick();
        cfg_vld = 1'b0;
    endtask

    task automatic send_words(input int first, input int count, input bit toggle);
        int  n;
        bit  took;
        for (int i = 0; i < count; i++) begin
            if (toggle && (i % 2 == 1)) begin
                ifmap_vld = 1'b0;
                tick();
            end
            ifmap_vld = 1'b1;
            ifmap_dat = DATA_W'(first + i);
            n = 0;
            took = 1'b0;
            while (!took && n < 200) begin
                @(negedge clk);
                took = ifmap_rdy;
                tick();
                n++;
            end
            if (!took) begin
                checks++;
                errors++;
                $display("FAIL send_timeout word=%0d not accepted within 200 cycles", first + i);
                ifmap_vld = 1'b0;
                return;
            end
        end
        ifmap_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want=0", name, exp_q.size());
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy !== 1'b0 || cfg_rdy !== 1'b1 || ifmap_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got busy=%b cfg_rdy=%b ifmap_rdy=%b want 0 1 0", name, busy, cfg_rdy, ifmap_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, ifmap_rdy, cfg_rdy, wen, switch_banks, job_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=000000", {busy, ifmap_rdy, cfg_rdy, wen, switch_banks, job_done});
        end
        checks++;
        if (wadr !== '0 || wdata !== '0) begin
            errors++;
            $display("FAIL reset_data got adr=%0d data=%h want 0 0", wadr, wdata);
        end
        #10;
        rst_n = 1'b1;
        #1;
        checks++;
        if (cfg_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg_rdy_before_clk got=%b want=0", cfg_rdy);
        end
        tick();
        check_idle("reset");
    endtask

    task automatic test_basic();
        configure(3, 1);
        exp_write(0, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
        exp_write(1, 64'h0008_0007_0006_0005, 1'b0, 1'b0);
        exp_write(2, 64'h000C_000B_000A_0009, 1'b1, 1'b1);
        send_words(1, 12, 1'b0);
        wait_drain("basic");
        check_idle("basic");
    endtask

    task automatic test_wait_free();
        configure(3, 2);
        exp_write(0, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
        exp_write(1, 64'h0008_0007_0006_0005, 1'b0, 1'b0);
        exp_write(2, 64'h000C_000B_000A_0009, 1'b1, 1'b0);
        exp_write(0, 64'h0010_000F_000E_000D, 1'b0, 1'b0);
        exp_write(1, 64'h0014_0013_0012_0011, 1'b0, 1'b0);
        exp_write(2, 64'h0018_0017_0016_0015, 1'b0, 1'b0);
        exp_switch(1'b1);
        send_words(1, 24, 1'b0);
        tick();
        tick();
        checks++;
        if (ifmap_rdy !== 1'b0 || busy !== 1'b1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL wait_free_stall got rdy=%b busy=%b pending=%0d want 0 1 1", ifmap_rdy, busy, exp_q.size());
        end
        tick();
        tick();
        tick();
        bank_free = 1'b1;
        tick();
        bank_free = 1'b0;
        wait_drain("wait_free");
        check_idle("wait_free");
    endtask

    task automatic test_coincident_free();
        configure(3, 2);
        exp_write(0, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
        exp_write(1, 64'h0008_0007_0006_0005, 1'b0, 1'b0);
        exp_write(2, 64'h000C_000B_000A_0009, 1'b1, 1'b0);
        exp_write(0, 64'h0010_000F_000E_000D, 1'b0, 1'b0);
        exp_write(1, 64'h0014_0013_0012_0011, 1'b0, 1'b0);
        exp_write(2, 64'h0018_0017_0016_0015, 1'b1, 1'b1);
        send_words(1, 24, 1'b0);
        // send_words returns inside the cycle carrying the final write
        bank_free = 1'b1;
        tick();
        bank_free = 1'b0;
        wait_drain("coincident");
        check_idle("coincident");
    endtask

    task automatic test_toggle();
        configure(3, 1);
        exp_write(0, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
        exp_write(1, 64'h0008_0007_0006_0005, 1'b0, 1'b0);
        exp_write(2, 64'h000C_000B_000A_0009, 1'b1, 1'b1);
        send_words(1, 12, 1'b1);
        wait_drain("toggle");
        check_idle("toggle");
    endtask

    task automatic test_zero_cfg();
        configure(0, 5);
        tick();
        check_idle("zero_words");
        configure(3, 0);
        tick();
        check_idle("zero_banks");
        bank_free = 1'b1;
        tick();
        bank_free = 1'b0;
        wait_drain("zero_cfg");
        check_idle("zero_cfg_free");
    endtask

    task automatic test_reset_midjob();
        configure(3, 1);
        exp_write(0, 64'h0067_0066_0065_0064, 1'b0, 1'b0);
        send_words(100, 6, 1'b0);
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midjob_before_reset got pending=%0d busy=%b want 0 1", exp_q.size(), busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ifmap_rdy, cfg_rdy, wen, switch_banks, job_done} !== 6'b0) begin
            errors++;
            $display("FAIL midjob_reset_ctrl got=%b want=000000", {busy, ifmap_rdy, cfg_rdy, wen, switch_banks, job_done});
        end
        checks++;
        if (wadr !== '0 || wdata !== '0) begin
            errors++;
            $display("FAIL midjob_reset_data got adr=%0d data=%h want 0 0", wadr, wdata);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checks++;
        if (cfg_rdy !== 1'b0) begin
            errors++;
            $display("FAIL midjob_cfg_rdy_before_clk got=%b want=0", cfg_rdy);
        end
        tick();
        check_idle("midjob_release");
        configure(3, 1);
        exp_write(0, 64'h00CB_00CA_00C9_00C8, 1'b0, 1'b0);
        exp_write(1, 64'h00CF_00CE_00CD_00CC, 1'b0, 1'b0);
        exp_write(2, 64'h00D3_00D2_00D1_00D0, 1'b1, 1'b1);
        send_words(200, 12, 1'b0);
        wait_drain("midjob_fresh");
        check_idle("midjob_fresh");
    endtask

`ifdef LOADER_FLUSH_EN
    task automatic test_flush();
        configure(3, 2);
        exp_write(0, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
        exp_write(1, 64'h0000_0000_0006_0005, 1'b1, 1'b1);
        send_words(1, 6, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain("flush");
        check_idle("flush");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wait_free();
        test_coincident_free();
        test_toggle();
        test_zero_cfg();
        test_reset_midjob();
`ifdef LOADER_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
